seg7_bcd_display: RTL

//  Sequential binary-to-decimal display driver for the board's 7-segment banks.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_digit_enc.sv | 29 ++
 rtl/seg7_bcd_display.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and the 7-segment decode table for seg7_bcd_display.
//   state_e     conversion FSM states
//   SEG_BLANK   all segments off (active-low form)
//   SEG_MINUS   segment g only (active-low form)
//   seg7_digit  BCD digit -> active-low {g..a}; non-decimal codes decode to blank
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg7_digit(logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// seg7_digit_enc: one 7-segment digit encoder (combinational).
//   digit  in  4  BCD digit
//   blank  in  1  force all segments off
//   minus  in  1  force segment g only (wins over blank)
//   seg    out 7  segments {g..a}, polarity set by ACTIVE_LOW
module seg7_digit_enc
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = seg7_digit(digit);
    if (minus) begin
      pat = SEG_MINUS;
    end else if (blank) begin
      pat = SEG_BLANK;
    end
    seg = ACTIVE_LOW ? pat : ~pat;
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display: sequential binary-to-BCD (double-dabble, one bit per clock)
// driving DIGITS registered 7-segment displays.
//   clk    in   1         rising-edge clock
//   rst_n  in   1         asynchronous active-low reset
//   start  in   1         convert request, din sampled on the same edge
//   din    in   WIDTH     unsigned value to display
//   busy   out  1         conversion in progress
//   done   out  1         one-cycle pulse, hex/ovf updated in this cycle
//   ovf    out  1         last value did not fit in DIGITS digits
//   hex    out  7*DIGITS  digit k = hex[7k+6:7k], k=0 is units
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DIGITS     = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [6:0] BlankOut = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH-1:0]    bin_q;
  logic [BcdW-1:0]     bcd_q;
  logic                ovf_acc_q;  // a 1 has been shifted out of the top digit

  logic [BcdW-1:0]     bcd_adj;
  logic                final_ovf;
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_next;

  always_comb begin
    logic [3:0] dig;
    logic       nz_above;
    bcd_adj   = '0;
    final_ovf = ovf_acc_q;
    blank     = '0;
    nz_above  = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      dig = bcd_q[4*d +: 4];
      bcd_adj[4*d +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
      if (dig > 4'd9) final_ovf = 1'b1;
    end
    // Walk down from the top digit; blank zeros until the first nonzero digit,
    // but always keep the units digit so zero shows as "0".
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      dig = bcd_q[4*d +: 4];
      blank[d] = BLANK_LZ && !nz_above && (dig == 4'd0) && (d != 0);
      if (dig != 4'd0) nz_above = 1'b1;
    end
  end

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_enc
    seg7_digit_enc #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
      .digit(bcd_q[4*k +: 4]),
      .blank(blank[k]),
      .minus(final_ovf),
      .seg  (seg_next[7*k +: 7])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_acc_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      hex       <= {DIGITS{BlankOut}};
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q     <= din;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          bin_q     <= bin_q << 1;
          bcd_q     <= {bcd_adj[BcdW-2:0], bin_q[WIDTH-1]};
          ovf_acc_q <= ovf_acc_q | bcd_adj[BcdW-1];
          cnt_q     <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            busy    <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          hex  <= seg_next;
          ovf  <= final_ovf;
          done <= 1'b1;
          if (start) begin
            bin_q     <= din;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
